// File: rtl/rd_tlp_axi_pkg.sv
// rd_tlp_axi_pkg: shared TLP/AXI constants, FSM state type and CplD header packing
package rd_tlp_axi_pkg;
  localparam int DOUBLE_WORD    = 32;
  localparam int HEADER_SIZE    = 4 * DOUBLE_WORD;
  localparam int TLP_DATA_WIDTH = 8 * DOUBLE_WORD;
  localparam int AXI_DATA_WIDTH = TLP_DATA_WIDTH;
  localparam int AXI_ADDR_WIDTH = 64;
  localparam int AXI_ID_WIDTH   = 8;

  localparam logic [7:0] MRD_3DW = 8'b000_00000;
  localparam logic [7:0] MRD_4DW = 8'b001_00000;
  localparam logic [7:0] CPLD    = 8'b010_01010;

  localparam int FMT_TYPE_LSB = 24;
  localparam int TC_LSB       = 20;
  localparam int ATTR_LSB     = 12;
  localparam int REQ_ID_LSB   = 16;
  localparam int TAG_LSB      = 8;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_SIZE_32B      = 3'b101;

  typedef enum logic [1:0] {IDLE, AR, DATA, DRAIN} state_t;

  // request fields needed later to build the completion header
  typedef struct packed {
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [4:0]  addr_lo;
  } req_t;

  // byte count is length*4 mod 4096, which is just the 10-bit length shifted by two
  function automatic logic [HEADER_SIZE-1:0] pack_cpld(req_t r, logic [15:0] cid);
    logic [31:0] dw0, dw1, dw2;
    dw0 = {CPLD, 1'b0, r.tc, 4'b0000, 2'b00, r.attr, 2'b00, r.len};
    dw1 = {cid, 3'b000, 1'b0, r.len, 2'b00};
    dw2 = {r.req_id, r.tag, 1'b0, r.addr_lo, 2'b00};
    return {32'h0, dw2, dw1, dw0};
  endfunction
endpackage

// File: rtl/rd_tlp_axi_if.sv
// rd_tlp_axi_if: request TLP, AXI AR/R and CplD TLP signals of the read bridge
interface rd_tlp_axi_if;
  import rd_tlp_axi_pkg::*;
  logic [HEADER_SIZE-1:0]    tlp_hdr;
  logic                      tlp_sop;
  logic                      tlp_eop;
  logic                      tlp_valid;
  logic                      tlp_ready;
  logic [AXI_ID_WIDTH-1:0]   axi_arid;
  logic [AXI_ADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]                axi_arlen;
  logic [2:0]                axi_arsize;
  logic [1:0]                axi_arburst;
  logic                      axi_arlock;
  logic [3:0]                axi_arcache;
  logic [2:0]                axi_arprot;
  logic                      axi_arvalid;
  logic                      axi_arready;
  logic [AXI_ID_WIDTH-1:0]   axi_rid;
  logic [AXI_DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]                axi_rresp;
  logic                      axi_rlast;
  logic                      axi_rvalid;
  logic                      axi_rready;
  logic [HEADER_SIZE-1:0]    cpl_hdr;
  logic [TLP_DATA_WIDTH-1:0] cpl_data;
  logic                      cpl_sop;
  logic                      cpl_eop;
  logic                      cpl_valid;
  logic                      cpl_ready;
  logic                      tlp_error;

  modport slave (
    input  tlp_hdr, tlp_sop, tlp_eop, tlp_valid,
    output tlp_ready,
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
    output axi_arcache, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready,
    output cpl_hdr, cpl_data, cpl_sop, cpl_eop, cpl_valid,
    input  cpl_ready,
    output tlp_error
  );

  modport master (
    output tlp_hdr, tlp_sop, tlp_eop, tlp_valid,
    input  tlp_ready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
    input  axi_arcache, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready,
    input  cpl_hdr, cpl_data, cpl_sop, cpl_eop, cpl_valid,
    output cpl_ready,
    input  tlp_error
  );
endinterface

// File: rtl/rd_tlp_axi.sv
// rd_tlp_axi: completer read path, MRd TLP -> one AXI INCR burst -> CplD TLP stream
module rd_tlp_axi
  import rd_tlp_axi_pkg::*;
#(
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input logic          clk,
  input logic          rst,
  rd_tlp_axi_if.slave  bus
);
  state_t                    r_state;
  req_t                      r_req;
  logic                      r_tlp_ready;
  logic                      r_arvalid;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                r_arlen;
  logic [AXI_ID_WIDTH-1:0]   r_arid;
  logic [7:0]                r_left;
  logic                      r_first;
  logic [HEADER_SIZE-1:0]    r_cpl_hdr;
  logic [TLP_DATA_WIDTH-1:0] r_cpl_data;
  logic                      r_cpl_sop;
  logic                      r_cpl_eop;
  logic                      r_cpl_valid;
  logic                      r_err;

  logic [31:0] w_dw0, w_dw1, w_dw2, w_dw3;
  logic [7:0]  w_fmt_type;
  logic        w_is_4dw;
  logic        w_is_mrd;
  logic [63:0] w_addr;
  logic [9:0]  w_len_m1;
  logic [7:0]  w_arlen;
  logic        w_accept;
  logic        w_rready;
  logic        w_rfire;
  logic        w_unused;

  assign w_dw0      = bus.tlp_hdr[31:0];
  assign w_dw1      = bus.tlp_hdr[63:32];
  assign w_dw2      = bus.tlp_hdr[95:64];
  assign w_dw3      = bus.tlp_hdr[127:96];
  assign w_fmt_type = w_dw0[FMT_TYPE_LSB +: 8];
  assign w_is_4dw   = w_fmt_type == MRD_4DW;
  assign w_is_mrd   = w_is_4dw || w_fmt_type == MRD_3DW;
  assign w_addr     = w_is_4dw ? {w_dw2, w_dw3[31:2], 2'b00} : {32'h0, w_dw2[31:2], 2'b00};
  // length field minus one wraps 0 to 1023, so beats-1 = (addr[4:2] + len - 1) / 8 with no special case
  assign w_len_m1   = w_dw0[9:0] - 10'd1;
  assign w_arlen    = 8'((11'(w_addr[4:2]) + 11'(w_len_m1)) >> 3);
  assign w_accept   = r_tlp_ready && bus.tlp_valid;
  assign w_rready   = r_state == DATA && (!r_cpl_valid || bus.cpl_ready);
  assign w_rfire    = w_rready && bus.axi_rvalid;
  assign w_unused   = ^{w_dw0[23], w_dw0[19:14], w_dw0[11:10], w_dw1[7:0], w_addr[1:0]};

  assign bus.tlp_ready   = r_tlp_ready;
  assign bus.axi_arid    = r_arid;
  assign bus.axi_araddr  = r_araddr;
  assign bus.axi_arlen   = r_arlen;
  assign bus.axi_arsize  = AXI_SIZE_32B;
  assign bus.axi_arburst = AXI_BURST_INCR;
  assign bus.axi_arlock  = 1'b0;
  assign bus.axi_arcache = AXI_CACHE_DEFAULT;
  assign bus.axi_arprot  = 3'b000;
  assign bus.axi_arvalid = r_arvalid;
  assign bus.axi_rready  = w_rready;
  assign bus.cpl_hdr     = r_cpl_hdr;
  assign bus.cpl_data    = r_cpl_data;
  assign bus.cpl_sop     = r_cpl_sop;
  assign bus.cpl_eop     = r_cpl_eop;
  assign bus.cpl_valid   = r_cpl_valid;
  assign bus.tlp_error   = r_err;

  // request decode, AR issue, R beat capture into the CplD output register, error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_tlp_ready <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arid      <= '0;
      r_left      <= '0;
      r_first     <= 1'b0;
      r_cpl_hdr   <= '0;
      r_cpl_data  <= '0;
      r_cpl_sop   <= 1'b0;
      r_cpl_eop   <= 1'b0;
      r_cpl_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_cpl_valid && bus.cpl_ready) r_cpl_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tlp_ready <= 1'b1;
          if (w_accept && bus.tlp_sop) begin
            if (!bus.tlp_eop) begin
              r_err   <= 1'b1;
              r_state <= DRAIN;
            end else if (!w_is_mrd) begin
              r_err <= 1'b1;
            end else begin
              r_state     <= AR;
              r_tlp_ready <= 1'b0;
              r_arvalid   <= 1'b1;
              r_araddr    <= {w_addr[63:5], 5'b00000};
              r_arlen     <= w_arlen;
              r_arid      <= w_dw1[TAG_LSB +: 8];
              r_left      <= w_arlen;
              r_first     <= 1'b1;
              r_req       <= '{tc: w_dw0[TC_LSB +: 3], attr: w_dw0[ATTR_LSB +: 2], len: w_dw0[9:0],
                               req_id: w_dw1[REQ_ID_LSB +: 16], tag: w_dw1[TAG_LSB +: 8],
                               addr_lo: w_addr[6:2]};
            end
          end
        end
        DRAIN: if (w_accept && bus.tlp_eop) r_state <= IDLE;
        AR: begin
          if (bus.axi_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_rfire) begin
            r_cpl_valid <= 1'b1;
            r_cpl_data  <= bus.axi_rdata;
            r_cpl_sop   <= r_first;
            r_cpl_eop   <= bus.axi_rlast;
            r_first     <= 1'b0;
            if (r_first) r_cpl_hdr <= pack_cpld(r_req, COMPLETER_ID);
            r_left      <= r_left == 8'd0 ? 8'd0 : r_left - 8'd1;
            r_err       <= bus.axi_rresp != 2'b00 || bus.axi_rid != r_arid || bus.axi_rlast != (r_left == 8'd0);
            if (bus.axi_rlast) begin
              r_state     <= IDLE;
              r_tlp_ready <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
